// File: rtl/iss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iss_pkg : shared types and default constants for the issue scheduler |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package iss_pkg;

  localparam int IQ_ROB_IDX_W = 4;
  localparam int IQ_DATA_W    = 32;
  localparam int DEF_LANES    = 4;
  localparam int DEF_ISSUE_W  = 2;

  typedef struct packed {
    logic                    needs_rob;
    logic [IQ_ROB_IDX_W-1:0] rob_idx;
    logic [IQ_DATA_W-1:0]    value;
  } operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
    operand_t c;
  } iq_entry_t;

  typedef struct packed {
    iq_entry_t            entry;
    logic [IQ_DATA_W-1:0] a_val;
    logic [IQ_DATA_W-1:0] b_val;
    logic [IQ_DATA_W-1:0] c_val;
  } iss_insn_t;

  // An operand is usable when it carries its own value or the ROB supplies it.
  function automatic logic opnd_ready(input operand_t op, input logic rob_vv);
    return !op.needs_rob || rob_vv;
  endfunction

  function automatic logic [IQ_DATA_W-1:0] opnd_value(input operand_t op,
                                                      input logic [IQ_DATA_W-1:0] rob_val);
    return op.needs_rob ? rob_val : op.value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iss_opnd_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iss_opnd_resolve : per-lane A/B/C operand resolution and lane-ready  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module iss_opnd_resolve
  import iss_pkg::*;
(
  input  iq_entry_t            insn,
  input  logic                 lane_valid,
  input  logic                 a_vv,
  input  logic                 b_vv,
  input  logic                 c_vv,
  input  logic [IQ_DATA_W-1:0] a_rv,
  input  logic [IQ_DATA_W-1:0] b_rv,
  input  logic [IQ_DATA_W-1:0] c_rv,
  output logic                 ready,
  output iss_insn_t            resolved
);

  assign ready = lane_valid && opnd_ready(insn.a, a_vv)
                            && opnd_ready(insn.b, b_vv)
                            && opnd_ready(insn.c, c_vv);

  always_comb begin
    resolved       = '0;
    resolved.entry = insn;
    resolved.a_val = opnd_value(insn.a, a_rv);
    resolved.b_val = opnd_value(insn.b, b_rv);
    resolved.c_val = opnd_value(insn.c, c_rv);
  end

endmodule
`default_nettype wire

// File: rtl/iss_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iss_sched : in-order issue scheduler, IQ prefix select + output reg  |
// | Optional perf counters enabled by defining ISS_PERF_CNT_EN.          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module iss_sched
  import iss_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int ISSUE_W   = DEF_ISSUE_W,
  // Operand struct widths come from iss_pkg; these must match them.
  parameter int ROB_IDX_W = IQ_ROB_IDX_W,
  parameter int DATA_W    = IQ_DATA_W,
  localparam int CNT_W    = $clog2(LANES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 empty,
  input  logic                 ext_valid   [LANES],
  input  iq_entry_t            insns       [LANES],
  output logic                 ext_enable,
  output logic [CNT_W-1:0]     ext_consumed,
  output logic [ROB_IDX_W-1:0] A_rob_idx   [LANES],
  output logic [ROB_IDX_W-1:0] B_rob_idx   [LANES],
  output logic [ROB_IDX_W-1:0] C_rob_idx   [LANES],
  input  logic                 A_val_valid [LANES],
  input  logic                 B_val_valid [LANES],
  input  logic                 C_val_valid [LANES],
  input  logic [DATA_W-1:0]    A_val       [LANES],
  input  logic [DATA_W-1:0]    B_val       [LANES],
  input  logic [DATA_W-1:0]    C_val       [LANES],
  output logic                 iss_valid   [ISSUE_W],
  output iss_insn_t            iss_insn    [ISSUE_W],
  input  logic                 iss_ready
`ifdef ISS_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall_exec,
  output logic [31:0]          perf_stall_opnd
`endif
);

  logic [LANES-1:0]   lane_rdy;
  iss_insn_t          res [LANES];
  logic [ISSUE_W-1:0] vld_q;
  logic [CNT_W-1:0]   k;
  logic               adv;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign A_rob_idx[i] = insns[i].a.rob_idx;
      assign B_rob_idx[i] = insns[i].b.rob_idx;
      assign C_rob_idx[i] = insns[i].c.rob_idx;

      iss_opnd_resolve u_resolve (
        .insn       (insns[i]),
        .lane_valid (ext_valid[i] && !empty),
        .a_vv       (A_val_valid[i]),
        .b_vv       (B_val_valid[i]),
        .c_vv       (C_val_valid[i]),
        .a_rv       (A_val[i]),
        .b_rv       (B_val[i]),
        .c_rv       (C_val[i]),
        .ready      (lane_rdy[i]),
        .resolved   (res[i])
      );
    end

    for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
      assign iss_valid[s] = vld_q[s];
    end
  endgenerate

  // Leading run of ready lanes, capped at the issue width.
  always_comb begin
    logic stop;
    k    = '0;
    stop = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!stop && lane_rdy[i] && (i < ISSUE_W)) begin
        k = k + CNT_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign adv          = !flush && ((vld_q == '0) || iss_ready);
  assign ext_consumed = (adv && !reset) ? k : '0;
  assign ext_enable   = (ext_consumed != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < ISSUE_W; s++) iss_insn[s] <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      for (int s = 0; s < ISSUE_W; s++) begin
        vld_q[s]    <= (s < int'(k));
        iss_insn[s] <= (s < int'(k)) ? res[s] : '0;
      end
    end
  end

`ifdef ISS_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issued     <= '0;
      perf_stall_exec <= '0;
      perf_stall_opnd <= '0;
    end else begin
      if (adv) perf_issued <= perf_issued + 32'(k);
      if (!adv && !flush) perf_stall_exec <= perf_stall_exec + 32'd1;
      if (adv && ext_valid[0] && !empty && !lane_rdy[0])
        perf_stall_opnd <= perf_stall_opnd + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/iss_sched.md
# iss_sched

Parametrised in-order issue scheduler between the instruction queue (IQ) and the execute units. Each cycle it examines the oldest `LANES` IQ entries and resolves their A/B/C operands through per-lane ROB forwarding ports. It selects the longest ready in-order prefix, up to `ISSUE_W` instructions, and tells the IQ how many it consumed. The selected group is registered into an output stage with a valid/ready handshake toward execute.

## Interface
Parameters:
- `LANES`, 4, IQ entries examined per cycle (≥1).
- `ISSUE_W`, 2, maximum instructions issued per cycle (1..`LANES`).
- `ROB_IDX_W`, 4, ROB index width.
- `DATA_W`, 32, operand width.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush; discards the output stage.
- `empty`  in  1  IQ empty; when set, all `ext_valid` are treated as 0.
- `ext_valid[LANES]`  in  1  IQ entry valid, lane 0 oldest.
- `insns[LANES]`  in  `iq_entry_t`  IQ entries.
- `ext_enable`  out  1  IQ pop strobe; equals (`ext_consumed` != 0).
- `ext_consumed`  out  `$clog2(LANES+1)`  entries popped this cycle.
- `A_rob_idx/B_rob_idx/C_rob_idx[LANES]`  out  `ROB_IDX_W`  ROB lookup index per lane and operand.
- `A_val_valid/B_val_valid/C_val_valid[LANES]`  in  1  ROB value available, same cycle.
- `A_val/B_val/C_val[LANES]`  in  `DATA_W`  ROB value.
- `iss_valid[ISSUE_W]`  out  1  output slot valid.
- `iss_insn[ISSUE_W]`  out  `iss_insn_t`  entry with resolved operand values.
- `iss_ready`  in  1  execute accepts the whole output group.

## Operation
- Operand X of lane i is ready when `insns[i].X.needs_rob` is 0 (value = `insns[i].X.value`) or when `X_val_valid[i]` is 1 (value = `X_val[i]`). `X_rob_idx[i]` = `insns[i].X.rob_idx`, always driven.
- Lane i is ready when `ext_valid[i]` is 1, `empty` is 0, and A, B and C are all ready.
- Selection: k = number of leading consecutive ready lanes starting at lane 0, capped at `ISSUE_W`. The first non-ready lane ends the group, so no entry issues out of order.
- Advance condition: `adv` = !`flush` && (no `iss_valid` set || `iss_ready`).
- When `adv` is true: `ext_consumed` = k. Output slots 0..k-1 load the selected lanes in order with `iss_valid` = 1. Slots k..`ISSUE_W`-1 load `iss_valid` = 0. If k = 0, the stage loads a bubble.
- When `adv` is false: `ext_consumed` = 0, `ext_enable` = 0, and the output register holds.
- `flush`: all `iss_valid` are cleared next cycle and nothing is consumed this cycle. `flush` has priority over `iss_ready` and over selection.
- Dependencies inside one group are not bypassed. The ROB reports such a value as not valid, which stalls the dependent lane naturally.

## Timing
- IQ/ROB to `ext_consumed`/`ext_enable`: combinational in the same cycle N. The issued group appears on `iss_*` at cycle N+1.
- Issue latency is 1 cycle. Sustained throughput is `ISSUE_W` per cycle while `iss_ready` = 1.
- Reset values: all `iss_valid` = 0, `iss_insn` = 0, perf counters = 0. During `reset`, `ext_consumed` = 0.
- A reset asserted mid-stall discards the held group. The IQ keeps its entries, because nothing was consumed.
- `empty` = 1 and all `ext_valid` = 0 behave identically: k = 0.

## Configuration
- `ISS_PERF_CNT_EN`: when defined, adds 32-bit outputs `perf_issued` (+k per advancing cycle), `perf_stall_exec` (+1 per cycle with `adv` = 0 and no flush) and `perf_stall_opnd` (+1 per advancing cycle with lane 0 valid but not ready).
  - All three counters wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Shared package `iss_pkg`:
  - `operand_t` (`needs_rob`, `rob_idx`, `value`).
  - `iq_entry_t`, which carries the A/B/C `operand_t` fields.
  - `iss_insn_t` (the entry plus three resolved `DATA_W` values).
  - Default constants for `ISSUE_W` and `LANES`.
- Sub-module `iss_opnd_resolve`: one instance per lane. It resolves the three operands and produces the lane-ready flag.
- The top level contains the prefix selector and the output register.

## Test plan
- `LANES`=4, `ISSUE_W`=2; four valid entries, all operands with `needs_rob`=0 → cycle N `ext_consumed`=2; cycle N+1 `iss_valid`=`{1,1}` holding lanes 0 and 1.
- Lane 0 B operand `needs_rob`=1, `B_val_valid[0]`=0 → `ext_consumed`=0 and a bubble is issued. Set `B_val_valid[0]`=1, `B_val[0]`=`32'hDEADBEEF` → lane 0 issues with B = `32'hDEADBEEF`.
- Lanes 0 and 2 ready, lane 1 not ready → `ext_consumed`=1 and only slot 0 is valid.
- `iss_valid` set with `iss_ready`=0 for 3 cycles → `ext_consumed`=0 and `iss_insn` stable for all 3 cycles. `perf_stall_exec`=3 with `ISS_PERF_CNT_EN`.
- `flush` and `iss_ready` both 1 with a valid group on the output → next cycle all `iss_valid`=0 and `ext_consumed`=0 in the flush cycle.
- `reset` asserted while a group is held → next cycle `iss_valid`=0 and counters = 0.
